// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and width default for the execute ALU
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_exec_unit_mul_div_core.sv
// rtl/alu_exec_unit_mul_div_core.sv - one-bit-per-cycle shift-add multiplier / restoring divider
module mul_div_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  // acc_hi/acc_lo hold {partial product, multiplier} or {remainder, dividend/quotient}
  logic             active;
  logic             mode_q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  // Next accumulator value for one iteration; on the last iteration this is the final answer
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    nxt_hi    = '0;
    nxt_lo    = '0;
    if (mode_q) begin
      // top bit of the difference is a borrow: restore when the trial subtract went negative
      if (!div_diff[WIDTH]) begin
        nxt_hi = div_diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  assign done = active && (count == LAST);
  assign out  = {nxt_hi, nxt_lo};

  // Load operands on start, iterate while active, stop on abort or after the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      mode_q <= 1'b0;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else if (start) begin
      active <= 1'b1;
      mode_q <= mode;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= a;
      opnd   <= b;
    end else if (abort || done) begin
      active <= 1'b0;
      count  <= '0;
    end else if (active) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      count  <= count + CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with iterative MULTU/DIVU into HI/LO
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             result_valid,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_state_t         state;
  logic               is_mul;
  logic               is_div;
  logic               accept;
  logic               core_start;
  logic               core_done;
  logic [2*WIDTH-1:0] core_out;
  logic [WIDTH-1:0]   alu_out;
  logic               slt;

  assign is_mul     = (operation == OP_MULTU);
  assign is_div     = (operation == OP_DIVU);
  assign busy       = (state != ST_IDLE);
  assign accept     = op_valid && (state == ST_IDLE);
  assign stall      = busy || (op_valid && (is_mul || is_div));
  // divide by zero is answered directly and never starts the iterative core
  assign core_start = accept && (is_mul || (is_div && (b != '0)));
  assign zero       = (result == '0);
  assign slt        = ($signed(a) < $signed(b));

  // Single-cycle result selection; unknown codes produce zero
  always_comb begin
    alu_out = '0;
    case (operation)
      OP_AND:  alu_out = a & b;
      OP_OR:   alu_out = a | b;
      OP_ADD:  alu_out = a + b;
      OP_SUB:  alu_out = a - b;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR:  alu_out = ~(a | b);
      OP_MFHI: alu_out = hi;
      OP_MFLO: alu_out = lo;
      default: alu_out = '0;
    endcase
  end

  mul_div_core #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .mode  (is_div),
    .abort (flush),
    .a     (a),
    .b     (b),
    .done  (core_done),
    .out   (core_out)
  );

  // Control FSM plus result and HI/LO registers; flush abandons an iterative op without writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      result       <= '0;
      result_valid <= 1'b0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            if (is_mul) begin
              state <= ST_MUL;
            end else if (is_div) begin
              if (b == '0) begin
                hi           <= a;
                lo           <= '1;
                result       <= '1;
                result_valid <= 1'b1;
              end else begin
                state <= ST_DIV;
              end
            end else begin
              result       <= alu_out;
              result_valid <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (core_done) begin
            hi           <= core_out[2*WIDTH-1:WIDTH];
            lo           <= core_out[WIDTH-1:0];
            result       <= core_out[WIDTH-1:0];
            result_valid <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_valid = 1'b0;
  logic [3:0]   operation = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         result_valid;
  logic         busy;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  alu_exec_unit #(.WIDTH(W), .ITER(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .operation    (operation),
    .a            (a),
    .b            (b),
    .flush        (flush),
    .result       (result),
    .zero         (zero),
    .result_valid (result_valid),
    .busy         (busy),
    .stall        (stall),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [W-1:0]   m_result = '0;
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;
  logic           m_rv = 1'b0;
  int             m_rem = 0;
  logic [2*W-1:0] m_pend = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // reference model: remaining-busy countdown, HI/LO from plain * / %
  always @(posedge clk) begin
    if (rst) begin
      m_result = '0; m_hi = '0; m_lo = '0; m_rv = 1'b0; m_rem = 0;
    end else begin
      m_rv = 1'b0;
      if (m_rem > 0) begin
        if (flush) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = m_pend[2*W-1:W]; m_lo = m_pend[W-1:0];
            m_result = m_lo; m_rv = 1'b1;
          end
        end
      end else if (op_valid) begin
        m_rv = 1'b1;
        case (operation)
          4'b0000: m_result = a & b;
          4'b0001: m_result = a | b;
          4'b0010: m_result = a + b;
          4'b0110: m_result = a - b;
          4'b0111: m_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          4'b1100: m_result = ~(a | b);
          4'b1000: begin m_pend = {32'b0, a} * {32'b0, b}; m_rem = W; m_rv = 1'b0; end
          4'b1001: begin
            if (b == 0) begin m_hi = a; m_lo = '1; m_result = '1; end
            else begin m_pend = {a % b, a / b}; m_rem = W; m_rv = 1'b0; end
          end
          4'b1010: m_result = m_hi;
          4'b1011: m_result = m_lo;
          default: m_result = '0;
        endcase
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("result", result, m_result);
      check("zero", zero, m_result == 0);
      check("result_valid", result_valid, m_rv);
      check("busy", busy, m_rem != 0);
      check("stall", stall, (m_rem != 0) || (op_valid && (operation == 4'b1000 || operation == 4'b1001)));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    operation = op; a = x; b = y; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    chk_en = 1'b1;
    settle();
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_hilo", {hi, lo}, 0);
    rst = 1'b0;
    step();

    do_op(4'b0010, 32'h7FFFFFFF, 32'd1); settle();
    check("add_wrap", result, 32'h80000000);
    check("add_zero", zero, 0);
    check("add_rv", result_valid, 1);
    do_op(4'b0110, 32'd5, 32'd5); settle();
    check("sub_res", result, 0);
    check("sub_zero", zero, 1);
    do_op(4'b0111, 32'hFFFFFFFF, 32'd1); settle();
    check("slt_neg", result, 1);
    do_op(4'b0000, 32'h0000F0F0, 32'h0000FF00); settle();
    check("and", result, 32'h0000F000);
    do_op(4'b1100, 32'd0, 32'd0); settle();
    check("nor", result, 32'hFFFFFFFF);
    do_op(4'b0011, 32'd6, 32'd7); settle();
    check("bad_op_res", result, 0);
    check("bad_op_rv", result_valid, 1);

    operation = 4'b1000; a = 32'hFFFFFFFF; b = 32'd2; op_valid = 1'b1;
    #1;
    check("mul_issue_stall", stall, 1);
    check("mul_issue_busy", busy, 0);
    step();
    operation = 4'b0010; a = 32'd1; b = 32'd1;
    repeat (4) step();
    op_valid = 1'b0;
    repeat (27) step();
    settle();
    check("mul_last_busy", busy, 1);
    check("mul_last_rv", result_valid, 0);
    step(); settle();
    check("mul_rv", result_valid, 1);
    check("mul_hi", hi, 1);
    check("mul_lo", lo, 32'hFFFFFFFE);
    check("mul_result", result, 32'hFFFFFFFE);
    check("mul_busy_done", busy, 0);

    do_op(4'b1001, 32'd100, 32'd7);
    repeat (32) step();
    settle();
    check("div_rv", result_valid, 1);
    check("div_lo", lo, 14);
    check("div_hi", hi, 2);
    do_op(4'b1010, 32'd0, 32'd0); settle();
    check("mfhi", result, 2);
    do_op(4'b1011, 32'd0, 32'd0); settle();
    check("mflo", result, 14);

    do_op(4'b1001, 32'd9, 32'd0); settle();
    check("div0_hi", hi, 9);
    check("div0_lo", lo, 32'hFFFFFFFF);
    check("div0_rv", result_valid, 1);
    check("div0_busy", busy, 0);

    flush = 1'b1;
    do_op(4'b0010, 32'd2, 32'd3);
    flush = 1'b0;
    settle();
    check("idle_flush_add", result, 5);

    do_op(4'b1000, 32'd4, 32'hC0000001);
    repeat (32) step();
    settle();
    check("preset_hi", hi, 3);
    check("preset_lo", lo, 4);

    do_op(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    settle();
    check("flush_busy", busy, 0);
    check("flush_hi", hi, 3);
    check("flush_lo", lo, 4);
    check("flush_rv", result_valid, 0);
    repeat (40) step();

    do_op(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("midrst_busy", busy, 0);
    check("midrst_hilo", {hi, lo}, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 1);
    check("midrst_rv", result_valid, 0);
    repeat (40) step();

    do_op(4'b0010, 32'd1, 32'd2); settle();
    check("post_rst_add", result, 3);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
